// File: rtl/comp_seq_pkg.sv
// comp_seq_pkg: shared FSM state encodings and nibble width for the sequential comparator
package comp_seq_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/comp_seq_comp4b.sv
// comp4b: combinational 4-bit unsigned magnitude comparator
module comp4b
    import comp_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = a > b;
    assign eq = a == b;
    // lt is the complement of gt, so it also reads 1 on equal
    assign lt = !gt;
endmodule

// File: rtl/comp_seq.sv
// comp_seq: multi-cycle magnitude comparator, one nibble per cycle MSB first,
// stopping at the first unequal nibble
module comp_seq
    import comp_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter bit SIGNED  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                 ready,
    output logic                 done,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq
);
    localparam int W = NIB_W * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    state_t state;
    logic [W-1:0] ra, rb;
    logic [IW-1:0] index;
    logic [NIB_W-1:0] na, nb;
    logic gt_c, eq_c, unused_lt;
    logic sign_diff, dec, dec_gt, dec_lt;
    comp4b u_comp4b (.a(na), .b(nb), .gt(gt_c), .lt(unused_lt), .eq(eq_c));
    always_comb begin
        na = ra[index*NIB_W +: NIB_W];
        nb = rb[index*NIB_W +: NIB_W];
        // opposite signs on the MSB nibble settle a signed compare immediately
        sign_diff = SIGNED && index == LAST && ra[W-1] != rb[W-1];
        dec = sign_diff || !eq_c;
        dec_gt = sign_diff ? rb[W-1] : gt_c;
        dec_lt = sign_diff ? ra[W-1] : !gt_c && !eq_c;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done <= 1'b0;
            gt <= 1'b0;
            lt <= 1'b0;
            eq <= 1'b0;
            index <= LAST;
            ra <= '0;
            rb <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    ra <= a;
                    rb <= b;
                    gt <= 1'b0;
                    lt <= 1'b0;
                    eq <= 1'b0;
                    index <= LAST;
                    ready <= 1'b0;
                    state <= ST_RUN;
                end
                ST_RUN: if (dec) begin
                    gt <= dec_gt;
                    lt <= dec_lt;
                    done <= 1'b1;
                    state <= ST_DONE;
                end else if (index == '0) begin
                    eq <= 1'b1;
                    done <= 1'b1;
                    state <= ST_DONE;
                end else begin
                    index <= index - 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: directed checks of comp_seq for unsigned, signed and single-nibble builds
module tb_comp_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st [3];
    logic [15:0] ta [3];
    logic [15:0] tbv [3];
    logic rdy [3], dn [3], g [3], l [3], e [3];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    comp_seq #(.NIBBLES(4), .SIGNED(1'b0)) u_uns (.clk(clk), .rst(rst), .start(st[0]), .a(ta[0]), .b(tbv[0]),
        .ready(rdy[0]), .done(dn[0]), .gt(g[0]), .lt(l[0]), .eq(e[0]));
    comp_seq #(.NIBBLES(4), .SIGNED(1'b1)) u_sgn (.clk(clk), .rst(rst), .start(st[1]), .a(ta[1]), .b(tbv[1]),
        .ready(rdy[1]), .done(dn[1]), .gt(g[1]), .lt(l[1]), .eq(e[1]));
    comp_seq #(.NIBBLES(1), .SIGNED(1'b0)) u_one (.clk(clk), .rst(rst), .start(st[2]), .a(ta[2][3:0]), .b(tbv[2][3:0]),
        .ready(rdy[2]), .done(dn[2]), .gt(g[2]), .lt(l[2]), .eq(e[2]));
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic wait_done(input int s, inout int cyc);
        while (!dn[s] && cyc < 40) begin
            @(negedge clk);
            st[s] = 1'b0;
            cyc++;
        end
    endtask
    task automatic run_job(input int s, input logic [15:0] av, input logic [15:0] bv, input int lat,
                           input logic xg, input logic xl, input logic xe, input bit inj);
        int cyc;
        @(negedge clk);
        check($sformatf("ready_pre%0d", s), int'(rdy[s]), 1);
        st[s] = 1'b1;
        ta[s] = av;
        tbv[s] = bv;
        @(negedge clk);
        st[s] = 1'b0;
        cyc = 1;
        if (inj) begin
            st[s] = 1'b1;
            ta[s] = '0;
            tbv[s] = '0;
        end
        wait_done(s, cyc);
        check($sformatf("lat%0d_%h_%h", s, av, bv), cyc, lat);
        check($sformatf("gt%0d_%h_%h", s, av, bv), int'(g[s]), int'(xg));
        check($sformatf("lt%0d_%h_%h", s, av, bv), int'(l[s]), int'(xl));
        check($sformatf("eq%0d_%h_%h", s, av, bv), int'(e[s]), int'(xe));
        check($sformatf("ready_done%0d", s), int'(rdy[s]), 0);
        @(negedge clk);
        check($sformatf("pulse%0d", s), int'(dn[s]), 0);
        check($sformatf("ready_post%0d", s), int'(rdy[s]), 1);
        check($sformatf("hold%0d", s), {29'd0, g[s], l[s], e[s]}, {29'd0, xg, xl, xe});
    endtask
    initial begin
        int cyc, pulses;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            ta[i] = '0;
            tbv[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset%0d", i), {27'd0, rdy[i], dn[i], g[i], l[i], e[i]}, 32'b10000);
        run_job(0, 16'h1234, 16'h1234, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_job(0, 16'h8000, 16'h7FFF, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(0, 16'h1233, 16'h1234, 5, 1'b0, 1'b1, 1'b0, 1'b1);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(dn[0]);
        end
        check("ignored_start_pulses", pulses, 0);
        run_job(0, 16'h12F0, 16'h1200, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(1, 16'h8000, 16'h7FFF, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job(1, 16'hFFFE, 16'hFFFF, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job(1, 16'h0001, 16'hFFFF, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(2, 16'h0003, 16'h0003, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        run_job(2, 16'h0005, 16'h0003, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        // reset in the second RUN cycle drops the job and clears the held result
        @(negedge clk);
        st[0] = 1'b1;
        ta[0] = 16'h1234;
        tbv[0] = 16'h1234;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_run", {27'd0, rdy[0], dn[0], g[0], l[0], e[0]}, 32'b10000);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(dn[0]);
        end
        check("rst_no_done", pulses, 0);
        // start held high: one ready cycle between back-to-back jobs
        st[1] = 1'b1;
        ta[1] = 16'hFFFF;
        tbv[1] = 16'h0001;
        @(negedge clk);
        cyc = 1;
        while (!dn[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("held_lat1", cyc, 2);
        check("held_lt1", int'(l[1]), 1);
        @(negedge clk);
        check("held_gap_ready", int'(rdy[1]), 1);
        check("held_gap_done", int'(dn[1]), 0);
        @(negedge clk);
        check("held_reaccept", int'(rdy[1]), 0);
        st[1] = 1'b0;
        cyc = 1;
        wait_done(1, cyc);
        check("held_lat2", cyc, 2);
        check("held_res2", {29'd0, g[1], l[1], e[1]}, 32'b010);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
